// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and default sizing for the single-clock FIFO
//               buffer and its storage array.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;
    localparam int AW         = $clog2(DEPTH);

    typedef logic                  bit_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [AW:0]           ptr_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : Simple dual-port DEPTH x DATA_WIDTH storage array with a
//               synchronous write port and a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int DEPTH      = fifo_pkg::DEPTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    import fifo_pkg::*;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read; holds the last word when no read is requested.
    // A same-address write at the same edge returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule : fifo_ram
`default_nettype wire

// File: rtl/fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_buffer
// Description : Single-clock FIFO with registered read data, full/empty
//               status, occupancy count and one-cycle overflow/underflow
//               error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_buffer #(
    parameter  int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter  int DEPTH      = fifo_pkg::DEPTH,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  wrclk,
    input  logic                  arst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);
    import fifo_pkg::*;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    bit_t        r_overflow;
    bit_t        r_underflow;

    bit_t w_full;
    bit_t w_empty;
    bit_t w_push_ok;
    bit_t w_pop_ok;

    // Status and acceptance decode; a push into a full FIFO is still taken
    // when a pop frees the oldest slot at the same edge.
    always_comb begin
        w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);
        w_empty   = (r_wr_ptr == r_rd_ptr);
        w_pop_ok  = pop && !w_empty;
        w_push_ok = push && (!w_full || w_pop_ok);
    end

    // Pointer advance and registered error pulses; rejected requests only
    // raise their pulse and leave the pointers alone.
    always_ff @(posedge wrclk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_overflow  <= push && !w_push_ok;
            r_underflow <= pop && !w_pop_ok;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk   (wrclk),
        .rst_n (arst_n),
        .we    (w_push_ok),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (data_in),
        .re    (w_pop_ok),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (data_out)
    );

    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_wr_ptr - r_rd_ptr;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule : fifo_buffer
`default_nettype wire

// File: tb/tb_fifo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_buffer
// Description : Self-checking bench for fifo_buffer: a directed vector
//               table, hand-written corner sequences and random traffic,
//               all checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_buffer;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int CW = $clog2(DP) + 1;

    logic          wrclk = 1'b0;
    logic          arst_n;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int errors = 0;
    int checks = 0;

    // Reference model: an ordered queue of stored words plus expected flags.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_udf;

    typedef struct {
        logic          push;
        logic [DW-1:0] din;
        logic          pop;
        logic [DW-1:0] dout;
        logic [CW-1:0] cnt;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          udf;
    } vec_t;

    vec_t tbl[10];

    fifo_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .wrclk     (wrclk),
        .arst_n    (arst_n),
        .push      (push),
        .data_in   (data_in),
        .pop       (pop),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 wrclk = ~wrclk;

    function automatic vec_t mk(logic p, logic [DW-1:0] d, logic o, logic [DW-1:0] dout,
                                int cnt, logic f, logic e, logic ov, logic ud);
        vec_t v;
        v.push = p; v.din = d; v.pop = o; v.dout = dout; v.cnt = CW'(cnt);
        v.full = f; v.empty = e; v.ovf = ov; v.udf = ud;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one clock of stimulus, then advance the model from its pre-edge state.
    task automatic cycle(logic p, logic [DW-1:0] d, logic o);
        bit pop_ok, push_ok;
        push = p; data_in = d; pop = o;
        @(posedge wrclk);
        #1;
        pop_ok  = o && (q.size() > 0);
        push_ok = p && ((q.size() < DP) || pop_ok);
        if (pop_ok)  m_dout = q.pop_front();
        if (push_ok) q.push_back(d);
        m_ovf = p && !push_ok;
        m_udf = o && !pop_ok;
    endtask

    task automatic check_model(string tag);
        chk({tag, ".data_out"},  int'(data_out),  int'(m_dout));
        chk({tag, ".count"},     int'(count),     q.size());
        chk({tag, ".full"},      int'(full),      int'(q.size() == DP));
        chk({tag, ".empty"},     int'(empty),     int'(q.size() == 0));
        chk({tag, ".overflow"},  int'(overflow),  int'(m_ovf));
        chk({tag, ".underflow"}, int'(underflow), int'(m_udf));
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
        model_reset();
        repeat (2) @(posedge wrclk);
        #1;
        check_model("reset");
        arst_n = 1'b1;

        // Directed table: in-order reads, drain to empty, underflow,
        // simultaneous push/pop on an empty FIFO.
        tbl[0] = mk(1, 8'h11, 0, 8'h00, 1, 0, 0, 0, 0);
        tbl[1] = mk(1, 8'h22, 0, 8'h00, 2, 0, 0, 0, 0);
        tbl[2] = mk(1, 8'h33, 0, 8'h00, 3, 0, 0, 0, 0);
        tbl[3] = mk(0, 8'h00, 1, 8'h11, 2, 0, 0, 0, 0);
        tbl[4] = mk(0, 8'h00, 1, 8'h22, 1, 0, 0, 0, 0);
        tbl[5] = mk(0, 8'h00, 1, 8'h33, 0, 0, 1, 0, 0);
        tbl[6] = mk(0, 8'h00, 1, 8'h33, 0, 0, 1, 0, 1);
        tbl[7] = mk(0, 8'h00, 0, 8'h33, 0, 0, 1, 0, 0);
        tbl[8] = mk(1, 8'h77, 1, 8'h33, 1, 0, 0, 0, 1);
        tbl[9] = mk(0, 8'h00, 1, 8'h77, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].push, tbl[i].din, tbl[i].pop);
            chk($sformatf("tbl%0d.data_out", i),  int'(data_out),  int'(tbl[i].dout));
            chk($sformatf("tbl%0d.count", i),     int'(count),     int'(tbl[i].cnt));
            chk($sformatf("tbl%0d.full", i),      int'(full),      int'(tbl[i].full));
            chk($sformatf("tbl%0d.empty", i),     int'(empty),     int'(tbl[i].empty));
            chk($sformatf("tbl%0d.overflow", i),  int'(overflow),  int'(tbl[i].ovf));
            chk($sformatf("tbl%0d.underflow", i), int'(underflow), int'(tbl[i].udf));
        end

        // Fill to full, reject a 17th push, then push+pop while full.
        for (int i = 0; i < DP; i++) begin
            cycle(1'b1, DW'(i), 1'b0);
            check_model("fill");
        end
        chk("fill.full_const", int'(full), 1);
        cycle(1'b1, 8'hAA, 1'b0);
        check_model("ovf");
        chk("ovf.pulse_const", int'(overflow), 1);
        cycle(1'b0, 8'h00, 1'b0);
        check_model("ovf_clear");
        cycle(1'b1, 8'h55, 1'b1);
        check_model("full_pushpop");
        chk("full_pushpop.dout_const", int'(data_out), 8'h00);
        for (int i = 0; i < DP; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            check_model("drain");
        end
        chk("drain.last_const", int'(data_out), 8'h55);

        // Forty push/pop pairs walk both pointers across the wrap point.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, DW'(8'h80 + i), 1'b0);
            check_model("wrap_push");
            cycle(1'b0, 8'h00, 1'b1);
            check_model("wrap_pop");
        end

        // Random traffic with a drifting push/pop bias to visit full and empty.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 0) ? 70 : 30;
            cycle(($urandom_range(99) < bias), DW'($urandom), ($urandom_range(99) >= bias));
            check_model("rand");
        end

        // Asynchronous reset in the middle of a cycle with data stored.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        #2;
        arst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        #3;
        arst_n = 1'b1;
        cycle(1'b0, 8'h00, 1'b1);
        check_model("post_rst_pop");
        chk("post_rst_udf_const", int'(underflow), 1);
        cycle(1'b0, 8'h00, 1'b0);
        check_model("post_rst_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_buffer
`default_nettype wire
